// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM burst master: FSM states, controller
// read/write encoding and default bus widths.
package sram_pkg;

  localparam int unsigned DEF_ADDR_W = 20;
  localparam int unsigned DEF_DATA_W = 16;

  // SRAM controller wr-line encoding (inverted sense: 1 means read)
  localparam logic MEM_RD = 1'b1;
  localparam logic MEM_WR = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DELIVER,
    S_DONE
  } state_t;

endpackage

// File: rtl/sram_timeout_cnt.sv
// Clear/enable cycle counter; o_tc flags the LIMIT-th enabled cycle since the
// last clear. The count saturates so a held enable never wraps.
module sram_timeout_cnt #(
  parameter int unsigned LIMIT = 64,
  parameter int unsigned CNT_W = $clog2(LIMIT + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      count <= '0;
    end else if (i_clr) begin
      count <= '0;
    end else if (i_en && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign o_tc = i_en && (count == LAST);

endmodule

// File: rtl/sram_burst_master.sv
// Burst initiator for the SRAM controller request/wait interface: one command
// becomes a sequence of single-word requests fed by / feeding valid-ready streams.
module sram_burst_master
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned LEN_W   = 10,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_rd,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [LEN_W-1:0]  i_cmd_len,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_wvalid,
  output logic              o_wready,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid,
  input  logic              i_rready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_mem_request,
  output logic              o_mem_wr,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_w_value,
  input  logic              i_mem_wait,
  input  logic [DATA_W-1:0] i_mem_r_value
);

  state_t           state;
  logic             rd;
  logic [LEN_W-1:0] remaining;
  logic             tmo_tc;

  sram_timeout_cnt #(
    .LIMIT (TIMEOUT)
  ) u_tmo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (state == S_ISSUE),
    .i_en  (state == S_WAIT),
    .o_tc  (tmo_tc)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= S_IDLE;
      rd            <= 1'b0;
      remaining     <= '0;
      o_cmd_ready   <= 1'b1;
      o_wready      <= 1'b0;
      o_rdata       <= '0;
      o_rvalid      <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
      o_mem_request <= 1'b0;
      o_mem_wr      <= MEM_WR;
      o_mem_addr    <= '0;
      o_mem_w_value <= '0;
    end else begin
      o_done        <= 1'b0;
      o_mem_request <= 1'b0;
      unique case (state)
        S_IDLE: begin
          // Ready rises one cycle into IDLE, so the cycle after DONE never accepts.
          o_cmd_ready <= 1'b1;
          if (i_cmd_valid && o_cmd_ready) begin
            o_cmd_ready <= 1'b0;
            o_busy      <= 1'b1;
            o_err       <= 1'b0;
            rd          <= i_cmd_rd;
            o_mem_wr    <= i_cmd_rd ? MEM_RD : MEM_WR;
            o_mem_addr  <= i_cmd_addr;
            remaining   <= i_cmd_len;
            if (i_cmd_len == '0) begin
              state  <= S_DONE;
              o_done <= 1'b1;
            end else if (i_cmd_rd) begin
              state         <= S_ISSUE;
              o_mem_request <= 1'b1;
            end else begin
              state    <= S_FETCH;
              o_wready <= 1'b1;
            end
          end
        end

        S_FETCH: begin
          if (i_wvalid) begin
            o_mem_w_value <= i_wdata;
            o_wready      <= 1'b0;
            o_mem_request <= 1'b1;
            state         <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          state <= S_WAIT;
        end

        S_WAIT: begin
          if (!i_mem_wait) begin
            o_mem_addr <= o_mem_addr + 1'b1;
            if (rd) begin
              o_rdata  <= i_mem_r_value;
              o_rvalid <= 1'b1;
              state    <= S_DELIVER;
            end else begin
              remaining <= remaining - 1'b1;
              if (remaining > LEN_W'(1)) begin
                state    <= S_FETCH;
                o_wready <= 1'b1;
              end else begin
                state  <= S_DONE;
                o_done <= 1'b1;
              end
            end
          end else if (tmo_tc) begin
            o_err  <= 1'b1;
            o_done <= 1'b1;
            state  <= S_DONE;
          end
        end

        S_DELIVER: begin
          if (i_rready) begin
            o_rvalid  <= 1'b0;
            remaining <= remaining - 1'b1;
            if (remaining > LEN_W'(1)) begin
              state         <= S_ISSUE;
              o_mem_request <= 1'b1;
            end else begin
              state  <= S_DONE;
              o_done <= 1'b1;
            end
          end
        end

        S_DONE: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_burst_master.sv
// Directed bench for sram_burst_master with a wait-holding SRAM controller model
// that answers reads with addr ^ 0x5A5A.
module tb_sram_burst_master;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic        i_cmd_rd = 1'b0;
  logic [19:0] i_cmd_addr = '0;
  logic [9:0]  i_cmd_len = '0;
  logic [15:0] i_wdata = '0;
  logic        i_wvalid = 1'b0;
  logic        o_wready;
  logic [15:0] o_rdata;
  logic        o_rvalid;
  logic        i_rready = 1'b0;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic        o_mem_request;
  logic        o_mem_wr;
  logic [19:0] o_mem_addr;
  logic [15:0] o_mem_w_value;
  logic        i_mem_wait;
  logic [15:0] i_mem_r_value;

  sram_burst_master #(
    .ADDR_W  (20),
    .DATA_W  (16),
    .LEN_W   (10),
    .TIMEOUT (64)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_rd      (i_cmd_rd),
    .i_cmd_addr    (i_cmd_addr),
    .i_cmd_len     (i_cmd_len),
    .i_wdata       (i_wdata),
    .i_wvalid      (i_wvalid),
    .o_wready      (o_wready),
    .o_rdata       (o_rdata),
    .o_rvalid      (o_rvalid),
    .i_rready      (i_rready),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err         (o_err),
    .o_mem_request (o_mem_request),
    .o_mem_wr      (o_mem_wr),
    .o_mem_addr    (o_mem_addr),
    .o_mem_w_value (o_mem_w_value),
    .i_mem_wait    (i_mem_wait),
    .i_mem_r_value (i_mem_r_value)
  );

  always #5 i_clk = ~i_clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Controller model: holds wait for wait_cfg cycles after each request.
  int unsigned wait_cfg = 0;
  int unsigned wait_left = 0;
  logic        hang = 1'b0;
  logic [15:0] rval = '0;
  int unsigned cyc = 0;
  logic [19:0] req_addr_q[$];
  logic        req_wr_q[$];
  logic [15:0] req_data_q[$];
  int unsigned req_cyc_q[$];

  assign i_mem_wait    = hang || (wait_left != 0);
  assign i_mem_r_value = rval;

  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (!i_rst) begin
      wait_left <= 0;
    end else if (o_mem_request) begin
      req_addr_q.push_back(o_mem_addr);
      req_wr_q.push_back(o_mem_wr);
      req_data_q.push_back(o_mem_w_value);
      req_cyc_q.push_back(cyc);
      wait_left <= wait_cfg;
      rval      <= o_mem_addr[15:0] ^ 16'h5A5A;
    end else if (wait_left != 0) begin
      wait_left <= wait_left - 1;
    end
  end

  int unsigned done_cnt = 0;
  always @(negedge i_clk) if (o_done) done_cnt++;

  logic        prev_req = 1'b0;
  int unsigned dbl_req = 0;
  always @(posedge i_clk) begin
    prev_req <= o_mem_request;
    if (o_mem_request && prev_req) dbl_req++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] log_addr(input int unsigned i);
    if (i < req_addr_q.size()) return 32'(req_addr_q[i]);
    return 32'hDEADBEEF;
  endfunction

  function automatic logic [31:0] log_wr(input int unsigned i);
    if (i < req_wr_q.size()) return 32'(req_wr_q[i]);
    return 32'hDEADBEEF;
  endfunction

  function automatic logic [31:0] log_data(input int unsigned i);
    if (i < req_data_q.size()) return 32'(req_data_q[i]);
    return 32'hDEADBEEF;
  endfunction

  function automatic logic [31:0] log_cyc(input int unsigned i);
    if (i < req_cyc_q.size()) return 32'(req_cyc_q[i]);
    return 32'hDEADBEEF;
  endfunction

  task automatic clear_log();
    req_addr_q.delete();
    req_wr_q.delete();
    req_data_q.delete();
    req_cyc_q.delete();
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic send_cmd(input logic rd, input logic [19:0] a, input logic [9:0] n);
    int unsigned k = 0;
    while (!o_cmd_ready && k < 100) begin
      @(negedge i_clk);
      k++;
    end
    if (!o_cmd_ready) check("cmd_ready_timeout", 32'(o_cmd_ready), 32'd1);
    i_cmd_valid = 1'b1;
    i_cmd_rd    = rd;
    i_cmd_addr  = a;
    i_cmd_len   = n;
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic feed_word(input logic [15:0] d);
    int unsigned k = 0;
    i_wdata  = d;
    i_wvalid = 1'b1;
    while (!o_wready && k < 200) begin
      @(negedge i_clk);
      k++;
    end
    if (!o_wready) check("wready_timeout", 32'(o_wready), 32'd1);
    @(negedge i_clk);
    i_wvalid = 1'b0;
  endtask

  task automatic recv_word(input string tag, input logic [15:0] exp, input bit stall,
                           input int unsigned exp_reqs);
    int unsigned k = 0;
    while (!o_rvalid && k < 200) begin
      @(negedge i_clk);
      k++;
    end
    check({tag, "_rvalid"}, 32'(o_rvalid), 32'd1);
    check({tag, "_rdata"}, 32'(o_rdata), 32'(exp));
    if (stall) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge i_clk);
        check({tag, "_stall_rvalid"}, 32'(o_rvalid), 32'd1);
        check({tag, "_stall_rdata"}, 32'(o_rdata), 32'(exp));
        check({tag, "_stall_reqs"}, 32'(req_addr_q.size()), 32'(exp_reqs));
      end
    end
    i_rready = 1'b1;
    @(negedge i_clk);
    i_rready = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int unsigned k = 0;
    while (!o_done && k < 300) begin
      @(negedge i_clk);
      k++;
    end
    if (!o_done) check({tag, "_done_timeout"}, 32'(o_done), 32'd1);
  endtask

  int unsigned done_base;
  int unsigned err_cyc;

  initial begin
    // reset values
    tick(3);
    check("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_req", 32'(o_mem_request), 32'd0);
    check("rst_mem_wr", 32'(o_mem_wr), 32'd0);
    check("rst_mem_addr", 32'(o_mem_addr), 32'd0);
    check("rst_w_value", 32'(o_mem_w_value), 32'd0);
    check("rst_wready", 32'(o_wready), 32'd0);
    check("rst_rvalid", 32'(o_rvalid), 32'd0);
    check("rst_rdata", 32'(o_rdata), 32'd0);
    i_rst = 1'b1;
    tick(2);

    // write burst, 8-cycle wait
    wait_cfg = 8;
    clear_log();
    done_base = done_cnt;
    send_cmd(1'b0, 20'h00010, 10'd3);
    check("wr_busy", 32'(o_busy), 32'd1);
    feed_word(16'h00A1);
    feed_word(16'h00B2);
    feed_word(16'h00C3);
    wait_done("wr");
    tick(4);
    check("wr_nreq", 32'(req_addr_q.size()), 32'd3);
    check("wr_addr0", log_addr(0), 32'h10);
    check("wr_addr1", log_addr(1), 32'h11);
    check("wr_addr2", log_addr(2), 32'h12);
    check("wr_data0", log_data(0), 32'hA1);
    check("wr_data1", log_data(1), 32'hB2);
    check("wr_data2", log_data(2), 32'hC3);
    check("wr_memwr0", log_wr(0), 32'd0);
    check("wr_memwr2", log_wr(2), 32'd0);
    check("wr_word_lat1", log_cyc(1) - log_cyc(0), 32'd11);
    check("wr_word_lat2", log_cyc(2) - log_cyc(1), 32'd11);
    check("wr_done_cnt", done_cnt - done_base, 32'd1);
    check("wr_idle_busy", 32'(o_busy), 32'd0);

    // read burst with back-pressure on word 2
    wait_cfg = 2;
    clear_log();
    done_base = done_cnt;
    send_cmd(1'b1, 20'h00200, 10'd3);
    recv_word("rd0", 16'h585A, 1'b0, 0);
    recv_word("rd1", 16'h585B, 1'b1, 2);
    recv_word("rd2", 16'h5858, 1'b0, 0);
    wait_done("rd");
    tick(4);
    check("rd_nreq", 32'(req_addr_q.size()), 32'd3);
    check("rd_addr0", log_addr(0), 32'h200);
    check("rd_addr1", log_addr(1), 32'h201);
    check("rd_addr2", log_addr(2), 32'h202);
    check("rd_memwr0", log_wr(0), 32'd1);
    check("rd_memwr2", log_wr(2), 32'd1);
    check("rd_done_cnt", done_cnt - done_base, 32'd1);

    // address wrap
    wait_cfg = 0;
    clear_log();
    send_cmd(1'b1, 20'hFFFFE, 10'd3);
    recv_word("wrap0", 16'hA5A4, 1'b0, 0);
    recv_word("wrap1", 16'hA5A5, 1'b0, 0);
    recv_word("wrap2", 16'h5A5A, 1'b0, 0);
    wait_done("wrap");
    tick(3);
    check("wrap_addr0", log_addr(0), 32'hFFFFE);
    check("wrap_addr1", log_addr(1), 32'hFFFFF);
    check("wrap_addr2", log_addr(2), 32'h00000);
    check("wrap_err", 32'(o_err), 32'd0);

    // zero-length command
    clear_log();
    done_base = done_cnt;
    send_cmd(1'b0, 20'h00123, 10'd0);
    check("len0_done", 32'(o_done), 32'd1);
    tick(1);
    check("len0_done_clr", 32'(o_done), 32'd0);
    check("len0_ready_gap", 32'(o_cmd_ready), 32'd0);
    tick(1);
    check("len0_ready", 32'(o_cmd_ready), 32'd1);
    check("len0_nreq", 32'(req_addr_q.size()), 32'd0);
    check("len0_done_cnt", done_cnt - done_base, 32'd1);

    // timeout: controller never releases wait
    hang = 1'b1;
    clear_log();
    done_base = done_cnt;
    send_cmd(1'b0, 20'h00040, 10'd2);
    feed_word(16'h1111);
    begin
      int unsigned k = 0;
      while (!o_err && k < 200) begin
        @(negedge i_clk);
        k++;
      end
      err_cyc = cyc;
      check("tmo_err", 32'(o_err), 32'd1);
      check("tmo_done_with_err", 32'(o_done), 32'd1);
      check("tmo_latency", 32'(err_cyc) - log_cyc(0), 32'd65);
    end
    hang = 1'b0;
    tick(4);
    check("tmo_nreq", 32'(req_addr_q.size()), 32'd1);
    check("tmo_done_cnt", done_cnt - done_base, 32'd1);
    check("tmo_err_sticky", 32'(o_err), 32'd1);
    check("tmo_idle", 32'(o_busy), 32'd0);
    send_cmd(1'b0, 20'h0, 10'd0);
    check("tmo_err_cleared", 32'(o_err), 32'd0);
    tick(3);

    // reset during WAIT of word 2
    wait_cfg = 20;
    clear_log();
    done_base = done_cnt;
    send_cmd(1'b0, 20'h00080, 10'd3);
    feed_word(16'h0001);
    feed_word(16'h0002);
    tick(2);
    check("rstmid_nreq", 32'(req_addr_q.size()), 32'd2);
    check("rstmid_busy_before", 32'(o_busy), 32'd1);
    #2 i_rst = 1'b0;
    #1;
    check("rstmid_req", 32'(o_mem_request), 32'd0);
    check("rstmid_busy", 32'(o_busy), 32'd0);
    check("rstmid_addr", 32'(o_mem_addr), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b1;
    tick(1);
    check("rstmid_ready", 32'(o_cmd_ready), 32'd1);
    check("rstmid_busy_after", 32'(o_busy), 32'd0);
    check("rstmid_no_done", done_cnt - done_base, 32'd0);

    // reset while the request pulse is high
    wait_cfg = 0;
    send_cmd(1'b1, 20'h00005, 10'd1);
    check("rstreq_req_high", 32'(o_mem_request), 32'd1);
    #1 i_rst = 1'b0;
    #1;
    check("rstreq_req_async", 32'(o_mem_request), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b1;
    tick(2);
    check("rstreq_ready", 32'(o_cmd_ready), 32'd1);

    check("req_single_cycle", 32'(dbl_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_burst_master.md
# sram_burst_master

Core-side initiator for the SRAM controller's request/wait interface. Accepts one burst command (start address, word count, direction), then issues one single-word request per word, honoring the controller's wait signal. Write data arrives on a valid/ready stream and read data leaves on one. Sits between the letter-recognition datapath and the SRAM controller, so bulk loads and reads need no per-word sequencing in the datapath.

## Interface
- ADDR_W, 20, SRAM word-address width
- DATA_W, 16, data word width
- LEN_W, 10, burst length width; maximum burst is 2^LEN_W-1 words
- TIMEOUT, 64, cycles allowed per word before the burst aborts with an error
- Reset is i_rst, asynchronous, active-low; clock is i_clk.
- i_clk  in  1  clock
- i_rst  in  1  async active-low reset
- i_cmd_valid  in  1  command offered
- o_cmd_ready  out  1  high only in IDLE
- i_cmd_rd  in  1  1 = read burst, 0 = write burst
- i_cmd_addr  in  ADDR_W  first word address
- i_cmd_len  in  LEN_W  word count
- i_wdata / i_wvalid / o_wready  in/in/out  DATA_W/1/1  write-data stream
- o_rdata / o_rvalid / i_rready  out/out/in  DATA_W/1/1  read-data stream
- o_busy  out  1  high in any state except IDLE
- o_done  out  1  one-cycle pulse at the end of a burst
- o_err  out  1  sticky timeout flag; cleared by accepting the next command
- o_mem_request  out  1  one-cycle request pulse to the controller
- o_mem_wr  out  1  controller encoding: 1 = read, 0 = write
- o_mem_addr  out  ADDR_W  request address; held stable for the whole access
- o_mem_w_value  out  DATA_W  write data; held stable for the whole access
- i_mem_wait  in  1  controller busy
- i_mem_r_value  in  DATA_W  read data

## Operation
- Command handshake: the command is accepted when i_cmd_valid && o_cmd_ready. On acceptance the block latches addr, len and rd; remaining = len, and err clears.
- len = 0 is a no-op: DONE on the next cycle, o_done pulses, and no memory access is issued.
- States:
  - IDLE: go to FETCH (write burst) or ISSUE (read burst) on acceptance.
  - FETCH: o_wready=1. On i_wvalid, latch the data and go to ISSUE.
  - ISSUE: o_mem_request=1 for exactly one cycle, then go to WAIT.
  - WAIT: stay here while i_mem_wait=1. The first cycle with i_mem_wait=0 is completion.
    - Read burst: capture i_mem_r_value and go to DELIVER.
    - Write burst: decrement remaining; go to FETCH if remaining>0, else to DONE.
  - DELIVER: o_rvalid=1 with o_rdata stable. On i_rready, decrement remaining; go to ISSUE if remaining>0, else to DONE.
  - DONE: o_done=1 for one cycle, then go to IDLE.
- Address update: incremented after every completed word, modulo 2^ADDR_W, so 0xFFFFF wraps to 0x00000 without error.
- o_mem_wr = rd, held for the whole burst. o_mem_addr and o_mem_w_value are driven from registers only and never from comb paths off inputs.
- Timeout: a counter clears in ISSUE and counts in WAIT. Reaching TIMEOUT sets o_err and moves to DONE; remaining words are abandoned.
- Reset mid-burst: all state clears immediately. o_mem_request drops asynchronously and no o_done is produced. An in-flight controller access is abandoned.

## Timing
- Reset values: o_cmd_ready=1, o_busy=0, o_done=0, o_err=0, o_mem_request=0, o_mem_wr=0, o_mem_addr=0, o_mem_w_value=0, o_wready=0, o_rvalid=0, o_rdata=0.
- The request cycle is never treated as completion: i_mem_wait is sampled only from the cycle after the request.
- A controller that holds wait for W cycles completes at request+W+1.
- Minimum per-word latency is 3 cycles (ISSUE, WAIT, then FETCH or DELIVER). With an eight-cycle wait, a write word takes 11 cycles.
- o_cmd_ready is registered: no new command is accepted in the cycle after DONE's o_done pulse.
- A valid-without-ready stall on either stream holds the FSM with no memory traffic.

## Structure
- Shared package (sram_pkg): state enum, the controller wr encoding constants (MEM_RD=1, MEM_WR=0), default ADDR_W/DATA_W.
- One natural sub-module: sram_timeout_cnt, a clear/enable counter with a terminal flag.

## Test plan
- Write burst: addr=0x00010, len=3, data A1,B2,C3 with the model controller holding wait 8 cycles. Expect 3 requests with o_mem_wr=0 at 0x10/0x11/0x12 carrying the matching data, then a single o_done.
- Read burst with back-pressure: model returns addr^0x5A5A. Holding i_rready low for 5 cycles on word 2 keeps o_rvalid and o_rdata stable, and the next request does not issue until accept.
- Wrap: addr=0xFFFFE, len=3 issues requests at 0xFFFFE, 0xFFFFF, 0x00000.
- len=0: o_done pulses one cycle after accept, and o_mem_request stays 0.
- Timeout: model never drops wait, with TIMEOUT=64. o_err rises 64 cycles into WAIT, o_done pulses, and the next accepted command clears o_err.
- Reset during WAIT of word 2: o_mem_request and o_busy are 0 immediately, and o_cmd_ready=1 after reset release.
